// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with req/gnt/rvalid memory port and prefetch buffer
//
// Purpose: holds the fetch PC and issues word reads to instruction memory.
//   Returned words are buffered and handed to ID as one {pc_o, inst_o} pair per cycle.
//   The stage honours ID stalls and one-cycle branch redirects.
// Build option: IF_PREFETCH_EN
//   defined   - FIFO_DEPTH-entry prefetch FIFO, so fetch runs ahead of ID.
//   undefined - single holding register, so the next fetch waits until the word reaches ID.
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   stall_i                          hold pc_o/inst_o/inst_valid_o and the buffer head
//   branch_flag_i, branch_target_i   redirect pulse and target (bits [1:0] ignored)
//   mem_req_o, mem_addr_o            read request and word-aligned address
//   mem_gnt_i                        request accepted
//   mem_rvalid_i, mem_rdata_i        in-order read return
//   pc_o, inst_o, inst_valid_o       registered IF/ID outputs
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    // Holding register: one entry, whatever FIFO_DEPTH says.
    localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;     // address of the request currently outstanding
    logic          drop;         // outstanding return belongs to a redirected-away stream
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [31:0]   tgt_aligned;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          fifo_wr;
    logic          room;
    logic          unused_tgt_bits;

    assign mem_addr_o      = fetch_pc;
    assign unused_tgt_bits = ^branch_target_i[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        tgt_aligned = {branch_target_i[31:2], 2'b00};
        // Only a return for our own outstanding request counts; a redirect in the
        // same cycle kills it without arming drop.
        push        = mem_rvalid_i && (state == S_WAIT) && !drop && !branch_flag_i;
        pop         = !stall_i && (count != '0);
        // Empty buffer and ID ready: the word goes straight into the output regs.
        bypass      = push && !stall_i && (count == '0);
        fifo_wr     = push && !bypass;
        if (branch_flag_i) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(fifo_wr) - CW'(pop);
        end
        // After a return nothing is outstanding, so the post-edge count is the whole occupancy.
        room = count_next < CW'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            drop      <= 1'b0;
            mem_req_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (branch_flag_i) fetch_pc <= tgt_aligned;
                    if (room) begin
                        state     <= S_REQ;
                        mem_req_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        req_addr  <= fetch_pc;
                        state     <= S_WAIT;
                        mem_req_o <= 1'b0;
                    end
                    if (branch_flag_i) begin
                        fetch_pc <= tgt_aligned;
                        if (mem_gnt_i) drop <= 1'b1;
                    end else if (mem_gnt_i) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        drop <= 1'b0;
                        if (room) begin
                            state     <= S_REQ;
                            mem_req_o <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (branch_flag_i) begin
                        drop <= 1'b1;
                    end
                    if (branch_flag_i) fetch_pc <= tgt_aligned;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_pc[wr_ptr]   <= req_addr;
            fifo_inst[wr_ptr] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pc_o         <= 32'h0;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end else begin
            count <= count_next;
            if (branch_flag_i) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                inst_o       <= NOP_INST;
                inst_valid_o <= 1'b0;
            end else begin
                if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
                if (!stall_i) begin
                    if (count != '0) begin
                        pc_o         <= fifo_pc[rd_ptr];
                        inst_o       <= fifo_inst[rd_ptr];
                        inst_valid_o <= 1'b1;
                        rd_ptr       <= ptr_inc(rd_ptr);
                    end else if (bypass) begin
                        pc_o         <= req_addr;
                        inst_o       <= mem_rdata_i;
                        inst_valid_o <= 1'b1;
                    end else begin
                        inst_o       <= NOP_INST;
                        inst_valid_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with a randomized in-order memory
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    if_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory responder knobs
    logic gnt_en = 1'b0;
    int   gnt_pct = 100;
    int   dly_lo = 1;
    int   dly_hi = 1;
    typedef struct { logic [31:0] addr; int dly; } pend_t;
    pend_t q[$];

    // Reference model: next PC expected on a valid output, and last observed outputs
    logic [31:0] exp_pc, prev_pc, prev_inst, prev_addr;
    logic        prev_valid, prev_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = RESET_PC; prev_pc = 32'h0; prev_inst = NOP; prev_valid = 1'b0;
        prev_req = 1'b0; prev_addr = RESET_PC;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, mem_req_o, 0);
        chk({tag, "_addr"}, mem_addr_o, RESET_PC);
        chk({tag, "_pc"}, pc_o, 0);
        chk({tag, "_inst"}, inst_o, NOP);
        chk({tag, "_valid"}, inst_valid_o, 0);
    endtask

    // One clock: drive stall/branch, then check outputs 1 time unit after the edge.
    task automatic cyc(input logic s, input logic b, input logic [31:0] tgt);
        logic g;
        stall_i = s; branch_flag_i = b; branch_target_i = tgt;
        @(posedge clk); #1;
        g = mem_gnt_i;
        chk("no_x", {31'b0, $isunknown({pc_o, inst_o, inst_valid_o, mem_req_o, mem_addr_o})}, 0);
        if (b) begin
            chk("bubble_valid", inst_valid_o, 0);
            chk("bubble_inst", inst_o, NOP);
            exp_pc = {tgt[31:2], 2'b00};
        end else if (s) begin
            chk("stall_pc", pc_o, prev_pc);
            chk("stall_inst", inst_o, prev_inst);
            chk("stall_valid", inst_valid_o, prev_valid);
        end else if (inst_valid_o) begin
            chk("seq_pc", pc_o, exp_pc);
            chk("seq_inst", inst_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end else begin
            chk("empty_inst", inst_o, NOP);
            chk("empty_pc", pc_o, prev_pc);
        end
        if (prev_req && !g && !b) begin
            chk("req_hold", mem_req_o, 1);
            chk("addr_hold", mem_addr_o, prev_addr);
        end
        prev_pc = pc_o; prev_inst = inst_o; prev_valid = inst_valid_o;
        prev_req = mem_req_o; prev_addr = mem_addr_o;
        branch_flag_i = 1'b0;
    endtask

    // In-order memory: grants per gnt_pct, returns after dly_lo..dly_hi cycles.
    initial begin
        pend_t h;
        forever begin
            @(posedge clk); #2;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (q.size() > 0) begin
                h = q[0];
                if (h.dly <= 1) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(h.addr);
                    void'(q.pop_front());
                end else begin
                    h.dly = h.dly - 1;
                    q[0] = h;
                end
            end
            mem_gnt_i = mem_req_o && gnt_en && (int'($urandom_range(99, 0)) < gnt_pct);
            if (mem_gnt_i) begin
                h.addr = mem_addr_o;
                h.dly  = int'($urandom_range(dly_hi, dly_lo));
                q.push_back(h);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic granted, seen, first;
        int   nval;

        // Reset values, checked before any clock edge (asynchronous reset)
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // T1: first fetch from RESET_PC, then 0x4, 0x8
        gnt_en = 1'b1; gnt_pct = 100; dly_lo = 1; dly_hi = 1;
        cyc(0, 0, 0);
        chk("t1_req0", mem_req_o, 1);
        chk("t1_addr0", mem_addr_o, 32'h0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t1_valid", inst_valid_o, 1);
        chk("t1_pc", pc_o, 32'h0);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_addr4", mem_addr_o, 32'h4);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t1_req8", mem_req_o, 1);
        chk("t1_addr8", mem_addr_o, 32'h8);

        // T2: long stall fills the buffer, fetch stops; drain gives exactly DEPTH words
        dly_lo = 1; dly_hi = 2;
        for (int i = 0; i < 16; i++) cyc(1, 0, 0);
        chk("t2_full_noreq", mem_req_o, 0);
        gnt_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0);
            chk("t2_drain_valid", inst_valid_o, 1);
        end
        cyc(0, 0, 0);
        chk("t2_after_drain", inst_valid_o, 0);

        // T4: grant withheld, request held, bubbles presented
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("t4_req", mem_req_o, 1);
        chk("t4_valid", inst_valid_o, 0);
        chk("t4_inst", inst_o, NOP);

        // T3: redirect to 0x103 while a return is pending
        gnt_en = 1'b1; dly_lo = 3; dly_hi = 3;
        granted = 1'b0;
        for (int i = 0; i < 20 && !granted; i++) begin
            cyc(0, 0, 0);
            granted = (q.size() > 0);
        end
        chk("t3_in_wait", granted, 1);
        cyc(0, 1, 32'h0000_0103);
        seen = 1'b0; first = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc(0, 0, 0);
            if (first && mem_req_o) begin
                chk("t3_req_addr", mem_addr_o, 32'h100);
                first = 1'b0;
            end
            seen = inst_valid_o;
        end
        chk("t3_valid_seen", seen, 1);
        chk("t3_pc", pc_o, 32'h100);

        // T5: reset during WAIT, late return must be ignored
        gnt_en = 1'b1; gnt_pct = 100; dly_lo = 5; dly_hi = 5;
        granted = 1'b0;
        for (int i = 0; i < 20 && !granted; i++) begin
            cyc(0, 0, 0);
            granted = (q.size() > 0);
        end
        chk("t5_granted", granted, 1);
        gnt_en = 1'b0;
        rst = 1'b1;
        #1 check_reset_outputs("t5_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            chk("t5_no_valid", inst_valid_o, 0);
        end
        chk("t5_req", mem_req_o, 1);
        chk("t5_addr", mem_addr_o, RESET_PC);
        gnt_en = 1'b1; dly_lo = 1; dly_hi = 2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(0, 0, 0);
            seen = inst_valid_o;
        end
        chk("t5_first_seen", seen, 1);
        chk("t5_first_pc", pc_o, RESET_PC);

        // T6: PC wrap from 0xFFFF_FFFC to 0x0
        cyc(0, 1, 32'hFFFF_FFFC);
        nval = 0;
        for (int i = 0; i < 40 && nval < 2; i++) begin
            cyc(0, 0, 0);
            if (inst_valid_o) nval++;
        end
        chk("t6_two_valid", nval, 2);
        chk("t6_wrap_pc", pc_o, 32'h0);

        // Randomized stall/redirect/memory timing against the sequence model
        gnt_pct = 60; dly_lo = 1; dly_hi = 3;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99, 0) < 30), ($urandom_range(99, 0) < 4), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
